servant_uart_rx: RTL

- Serial receiver for the 1-bit UART line `q` that servant firmware bit-bangs out.
- Deserialises 8N1 frames into bytes and buffers them in a small FIFO.
- Exposes the bytes on a valid/ready stream, so testbenches and host-side logic can consume console output cycle-accurately instead of by waveform inspection.
- Sits on the same `wb_clk` domain as the SoC, at the receiving end of `q`.

---
 rtl/servant_uart_rx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver feeding a small byte FIFO with a valid/ready output.
// Define SERVANT_UART_RX_PARITY_EN for 8E1 frames and an extra parity_err output.
module servant_uart_rx #(
    parameter int CLKS_PER_BIT = 556,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       wb_clk,
    input  logic       wb_rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef SERVANT_UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERVANT_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    logic        sync_q;
    logic        rs_q;
    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        push_q;
    logic        frame_err_q;
    logic        busy_q;
`ifdef SERVANT_UART_RX_PARITY_EN
    logic        par_q;
    logic        parity_err_q;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q <= 1'b1;
            rs_q   <= 1'b1;
        end else begin
            sync_q <= rx;
            rs_q   <= sync_q;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rs_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_RELOAD;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        if (!rs_q) begin
                            state_q <= DATA;
                            cnt_q   <= BIT_RELOAD;
                            idx_q   <= 3'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        shift_q <= {rs_q, shift_q[7:1]};
                        cnt_q   <= BIT_RELOAD;
                        if (idx_q == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`ifdef SERVANT_UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == 16'd0) begin
                        par_q   <= rs_q;
                        cnt_q   <= BIT_RELOAD;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (rs_q) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                            if (^{shift_q, par_q}) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                push_q <= 1'b1;
                            end
`else
                            push_q <= 1'b1;
`endif
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not be mistaken for the next start bit.
                    if (rs_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] wptr_d;
    logic [AW:0] rptr_q;
    logic [AW:0] rptr_d;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        overrun_q;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    always_comb begin
        pop     = !empty && rx_ready;
        push_ok = push_q && (!full || pop);
        wptr_d  = wptr_q + {{AW{1'b0}}, push_ok};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= push_q && full && !pop;
            if (push_ok) begin
                mem_q[wptr_q[AW-1:0]] <= shift_q;
            end
        end
    end

    assign rx_valid  = !empty;
    assign rx_data   = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef SERVANT_UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
